gate_bist: RTL and testbench

Parametrised built-in self-test engine for combinational gates and small combinational chips. On `start` it sweeps every input vector of an N_IN-input device under test and holds each vector for a programmable settle time. It compares the device outputs against a truth table supplied as a parameter, then reports a pass flag, the error count and the first failing vector. It is the self-checking, sequential successor to the per-gate directed benches and sits beside any gate or chip (Nand, And, Mux, half/full adder) in both simulation and FPGA bring-up.

---
 rtl/gate_bist_pkg.sv | 5 +
 rtl/gate_bist_settle.sv | 17 +
 rtl/gate_bist.sv | 79 +++++++
 tb/tb_gate_bist.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: state encoding and settle counter width shared by the gate BIST engine
package gate_bist_pkg;
  localparam int SETTLE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/gate_bist_settle.sv
// gate_bist_settle: per-vector settle counter, expired when the count reaches SETTLE
module gate_bist_settle
  import gate_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);
  logic [SETTLE_W-1:0] cnt;
  assign expired = cnt == SETTLE_W'(SETTLE);
  // The expiring edge is also the sampling edge, so the next vector restarts at zero
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr || expired) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gate_bist.sv
// gate_bist: sweeps every DUT input vector, compares against a truth table and reports results
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int M_OUT = 1,
  parameter int SETTLE = 2,
  parameter logic [M_OUT*(2**N_IN)-1:0] EXPECT = 4'b0111,
  parameter int ERR_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [M_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);
  state_t state;
  logic expired, mis;
  logic [ERR_W-1:0] err_nx;
  gate_bist_settle #(.SETTLE(SETTLE)) u_settle (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != DRIVE),
    .expired(expired)
  );
  assign mis = dut_out != EXPECT[int'(dut_in)*M_OUT +: M_OUT];
  assign err_nx = err_count + ERR_W'(mis && !(&err_count));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == DRIVE) begin
      if (abort) begin
        state <= IDLE;
        dut_in <= '0;
        busy <= 1'b0;
        pass <= 1'b0;
        err_count <= '0;
        first_fail_vec <= '0;
        first_fail_valid <= 1'b0;
      end else if (expired) begin
        err_count <= err_nx;
        if (mis && !first_fail_valid) begin
          first_fail_vec <= dut_in;
          first_fail_valid <= 1'b1;
        end
        if (&dut_in) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= err_nx == '0;
        end else
          dut_in <= dut_in + 1'b1;
      end
    end else if (start) begin
      state <= DRIVE;
      dut_in <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: scoreboard bench for a 2-input gate sweep and a full-adder sweep
module tb_gate_bist;
  typedef struct {int lat; int pass; int err; int fv; int ff;} res_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, fstart = 0;
  int mode = 0;
  logic [0:0] g_out;
  logic [1:0] g_in, g_ffv;
  logic [2:0] g_err;
  logic g_busy, g_done, g_pass, g_ffvalid;
  logic [1:0] f_out;
  logic [2:0] f_in, f_ffv;
  logic [3:0] f_err;
  logic f_busy, f_done, f_pass, f_ffvalid;
  res_t gq[$], fq[$];
  int nvec = 0, nbad = 0;
  always #5 clk = ~clk;
  // mode 0: Nand, 1: And, 2: stuck at 1
  always_comb g_out = mode == 0 ? ~(g_in[1] & g_in[0]) : mode == 1 ? (g_in[1] & g_in[0]) : 1'b1;
  always_comb f_out = {(f_in[2] & f_in[1]) | (f_in[0] & (f_in[2] ^ f_in[1])), ^f_in};
  gate_bist u_g (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(g_out),
    .dut_in(g_in), .busy(g_busy), .done(g_done), .pass(g_pass), .err_count(g_err),
    .first_fail_vec(g_ffv), .first_fail_valid(g_ffvalid)
  );
  gate_bist #(.N_IN(3), .M_OUT(2), .SETTLE(0), .EXPECT(16'hE994)) u_fa (
    .clk(clk), .rst_n(rst_n), .start(fstart), .abort(1'b0), .dut_out(f_out),
    .dut_in(f_in), .busy(f_busy), .done(f_done), .pass(f_pass), .err_count(f_err),
    .first_fail_vec(f_ffv), .first_fail_valid(f_ffvalid)
  );
  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  logic g_bp = 0, g_dp = 0, f_bp = 0, f_dp = 0;
  int g_t = 0, f_t = 0;
  always @(negedge clk) begin
    res_t e;
    g_t = (g_busy && !g_bp) ? 0 : g_t + 1;
    if (g_done && !g_dp) begin
      if (gq.size() == 0) chk("g_unexpected_done", 1, 0);
      else begin
        e = gq.pop_front();
        chk("g_latency", g_t, e.lat);
        chk("g_pass", g_pass, e.pass);
        chk("g_err_count", g_err, e.err);
        chk("g_ff_valid", g_ffvalid, e.fv);
        chk("g_ff_vec", g_ffv, e.ff);
      end
    end
    g_bp = g_busy;
    g_dp = g_done;
  end
  always @(negedge clk) begin
    res_t e;
    f_t = (f_busy && !f_bp) ? 0 : f_t + 1;
    if (f_done && !f_dp) begin
      if (fq.size() == 0) chk("f_unexpected_done", 1, 0);
      else begin
        e = fq.pop_front();
        chk("f_latency", f_t, e.lat);
        chk("f_pass", f_pass, e.pass);
        chk("f_err_count", f_err, e.err);
        chk("f_ff_valid", f_ffvalid, e.fv);
        chk("f_ff_vec", f_ffv, e.ff);
      end
    end
    f_bp = f_busy;
    f_dp = f_done;
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic pulse_fstart();
    fstart = 1;
    @(negedge clk);
    fstart = 0;
  endtask
  task automatic wait_g();
    int k = 0;
    while (!g_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("g_done_timeout", g_done, 1);
  endtask
  task automatic wait_f();
    int k = 0;
    while (!f_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("f_done_timeout", f_done, 1);
  endtask
  initial begin
    tick(3);
    chk("rst_dut_in", g_in, 0);
    chk("rst_busy", g_busy, 0);
    chk("rst_done", g_done, 0);
    chk("rst_pass", g_pass, 0);
    chk("rst_err", g_err, 0);
    chk("rst_ffvalid", g_ffvalid, 0);
    chk("rst_f_done", f_done, 0);
    chk("rst_f_dut_in", f_in, 0);
    rst_n = 1;
    tick(1);
    gq.push_back('{12, 1, 0, 0, 0});
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      chk("nand_seq", g_in, i / 3);
      start = (i == 4);
      @(negedge clk);
    end
    start = 0;
    wait_g();
    chk("done_busy", g_busy, 0);
    chk("done_hold_vec", g_in, 3);
    mode = 1;
    gq.push_back('{12, 0, 4, 1, 0});
    pulse_start();
    wait_g();
    tick(2);
    chk("and_hold_err", g_err, 4);
    mode = 2;
    gq.push_back('{12, 0, 1, 1, 3});
    pulse_start();
    wait_g();
    mode = 0;
    gq.push_back('{12, 1, 0, 0, 0});
    abort = 1;
    pulse_start();
    abort = 0;
    chk("start_wins_busy", g_busy, 1);
    wait_g();
    mode = 1;
    pulse_start();
    tick(4);
    chk("pre_abort_err", g_err, 1);
    abort = 1;
    tick(1);
    abort = 0;
    chk("abort_busy", g_busy, 0);
    chk("abort_done", g_done, 0);
    chk("abort_dut_in", g_in, 0);
    chk("abort_err", g_err, 0);
    chk("abort_ffvalid", g_ffvalid, 0);
    pulse_start();
    tick(5);
    chk("pre_rst_busy", g_busy, 1);
    rst_n = 0;
    tick(1);
    chk("midrst_dut_in", g_in, 0);
    chk("midrst_busy", g_busy, 0);
    chk("midrst_err", g_err, 0);
    chk("midrst_ffvalid", g_ffvalid, 0);
    chk("midrst_ffv", g_ffv, 0);
    rst_n = 1;
    mode = 0;
    gq.push_back('{12, 1, 0, 0, 0});
    pulse_start();
    wait_g();
    fq.push_back('{8, 1, 0, 0, 0});
    pulse_fstart();
    wait_f();
    chk("fa_pass_before_restart", f_pass, 1);
    fq.push_back('{8, 1, 0, 0, 0});
    pulse_fstart();
    chk("fa_restart_done", f_done, 0);
    chk("fa_restart_busy", f_busy, 1);
    chk("fa_restart_pass", f_pass, 0);
    chk("fa_restart_dut_in", f_in, 0);
    wait_f();
    tick(2);
    chk("g_queue_drained", gq.size(), 0);
    chk("f_queue_drained", fq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
